force_wb_arbiter: RTL

// Collects the one-cycle accumulated-force pulses from the NUM_ACC partial-force accumulators of
// one evaluation unit and serialises them onto the single force-cache writeback port.

---
 rtl/md_wb_pkg.sv | 32 +++
 rtl/wb_lane_fifo.sv | 47 ++++
 rtl/force_wb_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/md_wb_pkg.sv
// Shared types and widths for the force-cache writeback path.
// An entry carries a full particle ID plus three raw single-precision force components.
package md_wb_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int PARTICLE_ID_WIDTH = 20;
    localparam int CELL_ID_WIDTH     = 3;
    localparam int ID_WIDTH          = 3 * CELL_ID_WIDTH + PARTICLE_ID_WIDTH;

    localparam logic [CELL_ID_WIDTH-1:0] CELL_1 = 3'd1;
    localparam logic [CELL_ID_WIDTH-1:0] CELL_2 = 3'd2;
    localparam logic [CELL_ID_WIDTH-1:0] CELL_3 = 3'd3;

    typedef struct packed {
        logic [3*CELL_ID_WIDTH-1:0]   cell_id;
        logic [PARTICLE_ID_WIDTH-1:0] particle;
    } full_id_t;

    typedef struct packed {
        full_id_t              id;
        logic [DATA_WIDTH-1:0] fx;
        logic [DATA_WIDTH-1:0] fy;
        logic [DATA_WIDTH-1:0] fz;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_lane_fifo.sv
// Per-accumulator lane FIFO. A push into a full FIFO only lands when a pop frees a slot on the
// same edge; otherwise the entry is dropped and the parent records the overflow.
module wb_lane_fifo
    import md_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  logic      pop_i,
    input  wb_entry_t data_i,
    output wb_entry_t data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t      mem_q [DEPTH];
    logic [AW:0]    wrPtr_q;
    logic [AW:0]    rdPtr_q;
    logic           doPush;
    logic           doPop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q == {~rdPtr_q[AW], rdPtr_q[AW-1:0]});
    assign doPop   = pop_i & ~empty_o;
    assign doPush  = push_i & (~full_o | doPop);
    assign data_o  = mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/force_wb_arbiter.sv
// Serialises accumulated-force pulses from all accumulator lanes onto the force-cache writeback
// port through a round-robin arbiter and a registered valid/ready stage; tracks batch completion.
module force_wb_arbiter
    import md_wb_pkg::*;
#(
    parameter  int NUM_ACC      = 7,
    parameter  int FIFO_DEPTH   = 2,
    parameter  int QUIET_CYCLES = 4,
    localparam int SRC_W        = $clog2(NUM_ACC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_ACC-1:0]            in_acc_valid,
    input  logic [NUM_ACC*ID_WIDTH-1:0]   in_acc_id,
    input  logic [NUM_ACC*DATA_WIDTH-1:0] in_acc_force_x,
    input  logic [NUM_ACC*DATA_WIDTH-1:0] in_acc_force_y,
    input  logic [NUM_ACC*DATA_WIDTH-1:0] in_acc_force_z,
    input  logic [NUM_ACC-1:0]            in_start_wb,
    output logic                          out_wb_valid,
    input  logic                          in_wb_ready,
    output logic [ID_WIDTH-1:0]           out_wb_id,
    output logic [DATA_WIDTH-1:0]         out_wb_force_x,
    output logic [DATA_WIDTH-1:0]         out_wb_force_y,
    output logic [DATA_WIDTH-1:0]         out_wb_force_z,
    output logic [SRC_W-1:0]              out_wb_src,
    output logic                          out_batch_done,
    output logic [7:0]                    out_batch_count,
    output logic [NUM_ACC-1:0]            out_overflow
);

    wb_entry_t            laneIn   [NUM_ACC];
    wb_entry_t            laneHead [NUM_ACC];
    logic [NUM_ACC-1:0]   laneFull;
    logic [NUM_ACC-1:0]   laneEmpty;
    logic [NUM_ACC-1:0]   lanePop;

    logic                 outValid_q;
    wb_entry_t            outEntry_q;
    logic [SRC_W-1:0]     outSrc_q;
    logic [SRC_W-1:0]     rrPtr_q;
    logic [NUM_ACC-1:0]   overflow_q;

    logic                 grantValid;
    logic [SRC_W-1:0]     grantIdx;
    logic [SRC_W-1:0]     nextRr;
    int                   scanLane;
    logic                 loadEn;
    logic                 doLoad;

    wb_state_e            state_q, state_d;
    logic [7:0]           count_q, count_d;
    logic [3:0]           quiet_q, quiet_d;
    logic                 startPrev_q;
    logic                 startEdge;
    logic                 quietCond;
    logic                 accept;

    for (genvar g = 0; g < NUM_ACC; g++) begin : gLane
        assign laneIn[g] = {in_acc_id[g*ID_WIDTH +: ID_WIDTH],
                            in_acc_force_x[g*DATA_WIDTH +: DATA_WIDTH],
                            in_acc_force_y[g*DATA_WIDTH +: DATA_WIDTH],
                            in_acc_force_z[g*DATA_WIDTH +: DATA_WIDTH]};

        wb_lane_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (in_acc_valid[g]),
            .pop_i   (lanePop[g]),
            .data_i  (laneIn[g]),
            .data_o  (laneHead[g]),
            .full_o  (laneFull[g]),
            .empty_o (laneEmpty[g])
        );
    end

    // Scan lanes starting at the round-robin pointer; the first non-empty head wins.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        scanLane   = 0;
        for (int k = 0; k < NUM_ACC; k++) begin
            scanLane = (int'(rrPtr_q) + k) % NUM_ACC;
            if (!grantValid && !laneEmpty[scanLane]) begin
                grantValid = 1'b1;
                grantIdx   = SRC_W'(scanLane);
            end
        end
    end

    assign loadEn = ~outValid_q | in_wb_ready;
    assign doLoad = loadEn & grantValid;
    assign nextRr = (grantIdx == SRC_W'(NUM_ACC - 1)) ? '0 : grantIdx + 1'b1;

    always_comb begin
        lanePop = '0;
        if (doLoad) lanePop[grantIdx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            outEntry_q <= '0;
            outSrc_q   <= '0;
            rrPtr_q    <= '0;
            overflow_q <= '0;
        end else begin
            if (loadEn) begin
                outValid_q <= grantValid;
                if (grantValid) begin
                    outEntry_q <= laneHead[grantIdx];
                    outSrc_q   <= grantIdx;
                    rrPtr_q    <= nextRr;
                end
            end
            overflow_q <= overflow_q | (in_acc_valid & laneFull & ~lanePop);
        end
    end

    assign startEdge = (|in_start_wb) & ~startPrev_q;
    assign quietCond = (&laneEmpty) & ~outValid_q & ~(|in_acc_valid);
    assign accept    = outValid_q & in_wb_ready;

    // The quiet counter is compared before it can advance, so DONE follows one cycle after it fills.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        quiet_d = quiet_q;
        unique case (state_q)
            IDLE: begin
                if (startEdge) begin
                    state_d = ACTIVE;
                    count_d = '0;
                    quiet_d = '0;
                end
            end
            ACTIVE: begin
                if (accept && count_q != 8'hFF) count_d = count_q + 8'd1;
                if (quiet_q == 4'(QUIET_CYCLES)) begin
                    state_d = DONE;
                    quiet_d = '0;
                end else if (startEdge || !quietCond) begin
                    quiet_d = '0;
                end else begin
                    quiet_d = quiet_q + 4'd1;
                end
            end
            DONE: begin
                quiet_d = '0;
                if (startEdge) begin
                    state_d = ACTIVE;
                    count_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            quiet_q     <= '0;
            startPrev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            quiet_q     <= quiet_d;
            startPrev_q <= |in_start_wb;
        end
    end

    assign out_wb_valid    = outValid_q;
    assign out_wb_id       = outEntry_q.id;
    assign out_wb_force_x  = outEntry_q.fx;
    assign out_wb_force_y  = outEntry_q.fy;
    assign out_wb_force_z  = outEntry_q.fz;
    assign out_wb_src      = outSrc_q;
    assign out_batch_done  = (state_q == DONE);
    assign out_batch_count = count_q;
    assign out_overflow    = overflow_q;

endmodule
